// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the Rx refill controller.
package rx_ctrl_pkg;

  localparam int PKG_ID_W        = 24;
  localparam int PKG_TIMEOUT_CYC = 2048;
  localparam int ERR_CNT_W       = 8;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    REQ        = 2'd1,
    WAIT_FRAME = 2'd2,
    WAIT_EMPTY = 2'd3
  } rx_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == {ERR_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_req_timer.sv
// Loadable down-counter that times out an outstanding "need data" request.
module rx_req_timer
  import rx_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = PKG_TIMEOUT_CYC,
  localparam int W = $clog2(TIMEOUT_CYC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Counter register: load has priority, decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != {W{1'b0}})) begin
      cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == {W{1'b0}});

endmodule

// File: rtl/rx_refill_scheduler.sv
// Sequences "need data" requests for the Rx ping-pong buffer, retrying on
// timeout and checking the sequence of received frame IDs.
module rx_refill_scheduler
  import rx_ctrl_pkg::*;
#(
  parameter int              ID_W        = PKG_ID_W,
  parameter int              TIMEOUT_CYC = PKG_TIMEOUT_CYC,
  parameter int              MAX_RETRY   = 3,
  parameter logic [ID_W-1:0] FIRST_ID    = {ID_W{1'b0}}
) (
  input  logic                 ff_clk,
  input  logic                 rst_n,
  input  logic                 empty,
  input  logic                 start,
  input  logic                 rx_frame_stb,
  input  logic [ID_W-1:0]      frameid,
  output logic                 req,
  output logic [ID_W-1:0]      req_id,
  input  logic                 req_ack,
  output logic                 underrun,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = $clog2(MAX_RETRY + 1);

  rx_state_e            state, state_nx;
  logic [ID_W-1:0]      expect_id, expect_nx, req_id_nx;
  logic [RW-1:0]        retry_cnt, retry_nx;
  logic                 underrun_nx, seq_err_nx;
  logic [ERR_CNT_W-1:0] err_cnt_nx;
  logic                 pend, pend_set, pend_clr, empty_d;
  logic                 tmr_load, tmr_dec, tmr_zero;

  assign pend_set = empty & ~empty_d & start;

  rx_req_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (ff_clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TW'(TIMEOUT_CYC - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Next-state and output decode.
  always_comb begin
    state_nx    = state;
    req_id_nx   = req_id;
    expect_nx   = expect_id;
    retry_nx    = retry_cnt;
    underrun_nx = underrun;
    seq_err_nx  = 1'b0;
    err_cnt_nx  = err_cnt;
    pend_clr    = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (state)
      BOOT: begin
        state_nx  = REQ;
        req_id_nx = expect_id;
      end
      REQ: begin
        if (req_ack) begin
          state_nx = WAIT_FRAME;
          tmr_load = 1'b1;
        end else begin
          state_nx = REQ;
        end
      end
      WAIT_FRAME: begin
        // A frame beats a simultaneous timeout.
        if (rx_frame_stb) begin
          if (frameid != expect_id) begin
            seq_err_nx = 1'b1;
            err_cnt_nx = sat_inc(err_cnt);
          end else begin
            seq_err_nx = 1'b0;
          end
          expect_nx   = frameid + {{(ID_W-1){1'b0}}, 1'b1};
          retry_nx    = {RW{1'b0}};
          underrun_nx = 1'b0;
          state_nx    = WAIT_EMPTY;
        end else if (tmr_zero) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_nx = retry_cnt + {{(RW-1){1'b0}}, 1'b1};
          end else begin
            underrun_nx = 1'b1;
          end
          state_nx = REQ;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      WAIT_EMPTY: begin
        if (pend) begin
          state_nx  = REQ;
          req_id_nx = expect_id;
          pend_clr  = 1'b1;
        end else begin
          state_nx = WAIT_EMPTY;
        end
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

  // State and registered outputs; req follows the state being entered.
  always_ff @(posedge ff_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      expect_id <= FIRST_ID;
      req_id    <= FIRST_ID;
      retry_cnt <= {RW{1'b0}};
      underrun  <= 1'b0;
      seq_err   <= 1'b0;
      err_cnt   <= {ERR_CNT_W{1'b0}};
      pend      <= 1'b0;
      empty_d   <= 1'b0;
      req       <= 1'b0;
    end else begin
      state     <= state_nx;
      expect_id <= expect_nx;
      req_id    <= req_id_nx;
      retry_cnt <= retry_nx;
      underrun  <= underrun_nx;
      seq_err   <= seq_err_nx;
      err_cnt   <= err_cnt_nx;
      pend      <= pend_set | (pend & ~pend_clr);
      empty_d   <= empty;
      req       <= (state_nx == REQ);
    end
  end

endmodule
